// File: rtl/rd_scoreboard_if.sv
// ---------------------------------------------------------------------------
// rd_scoreboard_if
// Handshake bundle between the decoder / multi-cycle units (master side) and
// the issue scoreboard (slave side).
//   id_valid     decoded instruction present
//   id_ready     instruction may issue this cycle (driven by the scoreboard)
//   id_rs1/rs2/rd         register indices from decode
//   id_rs1/rs2/rd_idx_0   operand unused or x0 (decode-qualified)
//   id_rd_w_en   instruction writes rd
//   id_fu        target unit: 0 EXU, 1 MEM, 2 MUL, 3 DIV
//   id_serialize SYSTEM instruction, issues only when fully drained
//   wb_valid     a multi-cycle unit completes
//   wb_fu        completing unit (1..3)
//   wb_rd        completing destination (0 = no register write)
// ---------------------------------------------------------------------------
interface rd_scoreboard_if;
    logic       id_valid;
    logic       id_ready;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_rs1_idx_0;
    logic       id_rs2_idx_0;
    logic       id_rd_idx_0;
    logic       id_rd_w_en;
    logic [1:0] id_fu;
    logic       id_serialize;
    logic       wb_valid;
    logic [1:0] wb_fu;
    logic [4:0] wb_rd;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd,
        output id_rs1_idx_0, id_rs2_idx_0, id_rd_idx_0,
        output id_rd_w_en, id_fu, id_serialize,
        output wb_valid, wb_fu, wb_rd,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd,
        input  id_rs1_idx_0, id_rs2_idx_0, id_rd_idx_0,
        input  id_rd_w_en, id_fu, id_serialize,
        input  wb_valid, wb_fu, wb_rd,
        output id_ready
    );
endinterface

// File: rtl/rd_scoreboard.sv
// ---------------------------------------------------------------------------
// rd_scoreboard
// Issue-stage scheduler. Tracks integer registers awaiting a result from a
// multi-cycle unit (MEM, MUL, DIV) and which of those units are occupied.
// A decoded instruction is held (id_ready=0) on RAW, WAW, unit-busy or
// serialization hazards; on issue its destination is marked busy.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sb           rd_scoreboard_if.slave handshake bundle
//   busy_vec     registered busy bit per register (bit 0 always 0)
//   drained      no busy register and no occupied unit (registered state)
//   stall_cnt    cycles with id_valid=1 and id_ready=0 (wrapping)
//   wb_err       sticky: completion for an unoccupied unit / idle register
// ---------------------------------------------------------------------------
module rd_scoreboard (
    input  logic             clk,
    input  logic             rst_n,
    rd_scoreboard_if.slave   sb,
    output logic [31:0]      busy_vec,
    output logic             drained,
    output logic [31:0]      stall_cnt,
    output logic             wb_err
);

    logic [31:1] busy_reg;
    logic [31:1] busy_next;
    logic [3:1]  occ_reg;
    logic [3:1]  occ_next;
    logic [31:0] stall_cnt_reg;
    logic        wb_err_reg;

    // Register 0 and the EXU slot are hard-wired idle.
    logic [31:0] busy_cur;
    logic [3:0]  occ_cur;
    assign busy_cur = {busy_reg, 1'b0};
    assign occ_cur  = {occ_reg, 1'b0};

    // One-hot decode of completion and issue targets.
    logic [31:0] wb_rd_hit;
    logic [31:1] id_rd_hit;
    logic [3:0]  wb_fu_hit;
    logic [3:1]  id_fu_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_wb_rd
            assign wb_rd_hit[gi] = sb.wb_valid && (sb.wb_rd == 5'(gi));
        end
        for (gi = 1; gi < 32; gi++) begin : g_id_rd
            assign id_rd_hit[gi] = (sb.id_rd == 5'(gi));
        end
        for (gi = 0; gi < 4; gi++) begin : g_wb_fu
            assign wb_fu_hit[gi] = sb.wb_valid && (sb.wb_fu == 2'(gi));
        end
        for (gi = 1; gi < 4; gi++) begin : g_id_fu
            assign id_fu_hit[gi] = (sb.id_fu == 2'(gi));
        end
    endgenerate

    // Effective state: a same-cycle completion already frees its register
    // and unit, which gives zero-cycle wakeup of dependent instructions.
    logic [31:0] busy_e;
    logic [3:0]  occ_e;
    assign busy_e = busy_cur & ~wb_rd_hit;
    assign occ_e  = occ_cur & ~wb_fu_hit;

    logic haz_raw;
    logic haz_waw;
    logic haz_struct;
    logic haz_ser;
    logic ready_int;
    logic issue;
    logic set_busy;

    assign haz_raw    = (~sb.id_rs1_idx_0 & busy_e[sb.id_rs1]) |
                        (~sb.id_rs2_idx_0 & busy_e[sb.id_rs2]);
    assign haz_waw    = sb.id_rd_w_en & ~sb.id_rd_idx_0 & busy_e[sb.id_rd];
    assign haz_struct = occ_e[sb.id_fu];
    assign haz_ser    = sb.id_serialize & ((|busy_e) | (|occ_e));

    // Deliberately independent of id_valid so the decoder can look ahead.
    assign ready_int   = ~(haz_raw | haz_waw | haz_struct | haz_ser);
    assign sb.id_ready = ready_int;

    assign issue    = sb.id_valid & ready_int;
    // Only multi-cycle units own a destination; EXU results are forwarded.
    assign set_busy = issue & (sb.id_fu != 2'd0) & sb.id_rd_w_en & ~sb.id_rd_idx_0;

    // Set is OR-ed after the clear, so a new owner wins over a same-cycle
    // completion of the previous owner.
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy_next
            assign busy_next[gi] = (busy_reg[gi] & ~wb_rd_hit[gi]) |
                                   (set_busy & id_rd_hit[gi]);
        end
        for (gi = 1; gi < 4; gi++) begin : g_occ_next
            assign occ_next[gi] = (occ_reg[gi] & ~wb_fu_hit[gi]) |
                                  (issue & id_fu_hit[gi]);
        end
    endgenerate

    // Protocol checks use registered state, before any same-cycle set.
    logic wb_bad;
    assign wb_bad = sb.wb_valid &
                    ((sb.wb_fu == 2'd0) | ~occ_cur[sb.wb_fu] |
                     ((sb.wb_rd != 5'd0) & ~busy_cur[sb.wb_rd]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg      <= '0;
            occ_reg       <= '0;
            stall_cnt_reg <= '0;
            wb_err_reg    <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            occ_reg  <= occ_next;
            if (sb.id_valid && !ready_int) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (wb_bad) begin
                wb_err_reg <= 1'b1;
            end
        end
    end

    assign busy_vec  = busy_cur;
    assign drained   = ~(|busy_reg) & ~(|occ_reg);
    assign stall_cnt = stall_cnt_reg;
    assign wb_err    = wb_err_reg;

endmodule
